// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared constants, types and the segment decoder for the
// seven-segment scan-capture block.
//   - active-low segment patterns for 0-9 and blank (dp bit dropped)
//   - active-low one-hot anode selects and the display-off pattern
//   - digit position indices (SEC0..MIN1)
//   - capture FSM state type and decoder result struct
package seg_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_SEC0   = 4'b1110;
    localparam logic [3:0] AN_SEC1   = 4'b1101;
    localparam logic [3:0] AN_MIN0   = 4'b1011;
    localparam logic [3:0] AN_MIN1   = 4'b0111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    localparam logic [1:0] SEC0 = 2'd0;
    localparam logic [1:0] SEC1 = 2'd1;
    localparam logic [1:0] MIN0 = 2'd2;
    localparam logic [1:0] MIN1 = 2'd3;

    typedef enum logic {
        ST_SETTLE,
        ST_HOLD
    } scan_state_t;

    typedef struct packed {
        logic       valid;  // code is a digit or blank
        logic       blank;  // code is blank
        logic [3:0] bcd;    // decoded digit (0 when blank/invalid)
    } seg_dec_t;

    function automatic seg_dec_t seg_decode(input logic [6:0] seg);
        seg_dec_t d;
        d.valid = 1'b1;
        d.blank = 1'b0;
        d.bcd   = 4'd0;
        case (seg)
            SEG_0:     d.bcd = 4'd0;
            SEG_1:     d.bcd = 4'd1;
            SEG_2:     d.bcd = 4'd2;
            SEG_3:     d.bcd = 4'd3;
            SEG_4:     d.bcd = 4'd4;
            SEG_5:     d.bcd = 4'd5;
            SEG_6:     d.bcd = 4'd6;
            SEG_7:     d.bcd = 4'd7;
            SEG_8:     d.bcd = 4'd8;
            SEG_9:     d.bcd = 4'd9;
            SEG_BLANK: d.blank = 1'b1;
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_bus_sync.sv
// seg_bus_sync: WIDTH-bit two-flop synchronizer with asynchronous
// active-low reset to RST_VAL.
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset
//   i_d     - asynchronous input bus
//   o_q     - synchronized bus
module seg_bus_sync #(
    parameter int unsigned           WIDTH   = 12,
    parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed active-low anode/segment display
// bus and decodes each stable digit back to BCD.
//   clk          - system clock
//   rst          - asynchronous active-low reset
//   anode_count  - active-low one-hot digit select (1110 = sec0 .. 0111 = min1)
//   seven_seg    - active-low segments {dp, g..a}
//   sec0..min1   - last decoded BCD per position
//   digit_valid  - position captured since reset / last timeout
//   blank_seen   - most recent capture at that position was blank
//   frame_done   - pulse when all four positions captured since last pulse
//   err          - pulse on illegal anode or undecodable segment code
//   err_count    - saturating count of err pulses
// Build option: define SEG_SCAN_ERR_EN to enable err/err_count; otherwise
// both are tied low and illegal codes are silently ignored.
module seg_scan_capture #(
    parameter int unsigned STABLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anode_count,
    input  logic [7:0] seven_seg,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic [3:0] digit_valid,
    output logic [3:0] blank_seen,
    output logic       frame_done,
    output logic       err,
    output logic [7:0] err_count
);
    import seg_scan_pkg::*;

    localparam int unsigned     TO_W     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      STAB_MAX = 8'(STABLE_CYCLES - 1);

    logic [11:0]     w_samp;
    logic [11:0]     r_prev;
    logic            w_chg;
    logic [7:0]      r_stab_cnt;
    scan_state_t     r_state;
    scan_state_t     w_state_nxt;
    logic            w_capture;
    seg_dec_t        w_dec;
    logic            w_an_legal;
    logic [1:0]      w_pos;
    logic [3:0]      w_pos_oh;
    logic            w_cap_ok;
    logic            w_timeout;
    logic [3:0]      w_valid_base;
    logic [3:0]      w_mask_base;
    logic [3:0]      w_mask_new;
    logic [3:0]      r_bcd [4];
    logic [3:0]      r_valid;
    logic [3:0]      r_blank;
    logic [3:0]      r_mask;
    logic            r_frame;
    logic [TO_W-1:0] r_to_cnt;

    // Idle bus (all ones) is the reset value so reset looks like display-off.
    seg_bus_sync #(
        .WIDTH   (12),
        .RST_VAL (12'hFFF)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_d     ({anode_count, seven_seg}),
        .o_q     (w_samp)
    );

    assign w_chg = (w_samp != r_prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev     <= '1;
            r_stab_cnt <= '0;
        end else begin
            r_prev <= w_samp;
            if (w_chg) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != STAB_MAX) begin
                r_stab_cnt <= r_stab_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_SETTLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture fires only on the SETTLE->HOLD edge, giving one capture per dwell.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_SETTLE: begin
                if (!w_chg && (r_stab_cnt == STAB_MAX)) begin
                    w_state_nxt = ST_HOLD;
                    w_capture   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_chg) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: w_state_nxt = ST_SETTLE;
        endcase
    end

    always_comb begin
        w_an_legal = 1'b1;
        w_pos      = SEC0;
        case (w_samp[11:8])
            AN_SEC0: w_pos = SEC0;
            AN_SEC1: w_pos = SEC1;
            AN_MIN0: w_pos = MIN0;
            AN_MIN1: w_pos = MIN1;
            default: w_an_legal = 1'b0;
        endcase
    end

    assign w_dec        = seg_decode(w_samp[6:0]);
    assign w_pos_oh     = 4'b0001 << w_pos;
    assign w_cap_ok     = w_capture && w_an_legal && w_dec.valid;
    assign w_timeout    = (r_to_cnt == TO_MAX);
    assign w_valid_base = w_timeout ? 4'b0000 : r_valid;
    assign w_mask_base  = w_timeout ? 4'b0000 : r_mask;
    assign w_mask_new   = w_mask_base | w_pos_oh;

    // A capture coinciding with a timeout still lands: the timeout clears
    // the other bits, then the captured position is set on top.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bcd    <= '{default: 4'd0};
            r_valid  <= '0;
            r_blank  <= '0;
            r_mask   <= '0;
            r_frame  <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_frame  <= 1'b0;
            r_to_cnt <= (w_cap_ok || w_timeout) ? '0 : r_to_cnt + TO_W'(1);
            r_valid  <= w_cap_ok ? (w_valid_base | w_pos_oh) : w_valid_base;
            if (w_cap_ok) begin
                if (!w_dec.blank) begin
                    r_bcd[w_pos] <= w_dec.bcd;
                end
                r_blank[w_pos] <= w_dec.blank;
                if (w_mask_new == 4'hF) begin
                    r_mask  <= '0;
                    r_frame <= 1'b1;
                end else begin
                    r_mask <= w_mask_new;
                end
            end else begin
                r_mask <= w_mask_base;
            end
        end
    end

    assign sec0        = r_bcd[SEC0];
    assign sec1        = r_bcd[SEC1];
    assign min0        = r_bcd[MIN0];
    assign min1        = r_bcd[MIN1];
    assign digit_valid = r_valid;
    assign blank_seen  = r_blank;
    assign frame_done  = r_frame;

`ifdef SEG_SCAN_ERR_EN
    logic       w_cap_err;
    logic       r_err;
    logic [7:0] r_err_cnt;

    // Display-off (all anodes high) is not an error.
    assign w_cap_err = w_capture &&
                       (w_an_legal ? !w_dec.valid : (w_samp[11:8] != ANODE_OFF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_cap_err;
            if (w_cap_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err       = r_err;
    assign err_count = r_err_cnt;
`else
    assign err       = 1'b0;
    assign err_count = '0;
`endif

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side counterpart of the stopwatch display multiplexer. The block samples the time-multiplexed anode/segment bus (`anode_count`, `seven_seg`) and decodes each active digit's segment pattern back to BCD. It latches the four digit positions and reports blanking (blink) and frame completion. It is used for board-level loopback self-check and as the scoreboard front end in display verification.

## Interface
Parameters:
- `STABLE_CYCLES`, 16: consecutive `clk` cycles the synchronized bus must stay unchanged before a capture (range 2–255).
- `TIMEOUT_CYCLES`, 1048576: number of `clk` cycles without a capture after which all `digit_valid` bits clear.

Ports:
- `clk`, input, 1: single system clock (100 MHz).
- `rst`, input, 1: asynchronous, active-low reset.
- `anode_count`, input, 4: active-low one-hot digit select. `4'b1110` selects sec0, `1101` sec1, `1011` min0, `0111` min1.
- `seven_seg`, input, 8: active-low segments. Bit 7 is dp, bits 6:0 are g..a.
- `sec0`, `sec1`, `min0`, `min1`, output, 4 each: last decoded BCD value per position.
- `digit_valid`, output, 4: per-position flag meaning that position holds a value captured since reset or the last timeout. Bit 0 is sec0, bit 3 is min1.
- `blank_seen`, output, 4: per-position flag meaning the most recent capture at that position was blank.
- `frame_done`, output, 1: one-cycle pulse when all four positions have been captured since the previous pulse.
- `err`, output, 1: one-cycle pulse on an illegal anode pattern or an undecodable segment code.
- `err_count`, output, 8: saturating count of `err` pulses.

## Operation
- **Input synchronization:** both input buses pass through a 2-flop synchronizer into a sampled register.
- **Stability counter:** reset to 0 whenever the sampled value differs from its previous value; otherwise it increments and saturates at `STABLE_CYCLES-1`.
- **State machine.** Two states, SETTLE and HOLD; reset state is SETTLE.
  - SETTLE → HOLD when the counter reaches `STABLE_CYCLES-1`. A capture happens on that transition.
  - HOLD → SETTLE on any change of the sampled value.
  - Result: exactly one capture per stable dwell.
- **Capture, legal anode.** The anode pattern is one of the four one-hot-low codes.
  - Decode `seven_seg[6:0]` with dp ignored: `C0`→0, `F9`→1, `A4`→2, `B0`→3, `99`→4, `92`→5, `82`→6, `F8`→7, `80`→8, `90`→9, using the 8-bit values with dp=1. Blank is `7'h7F`.
  - Digit code: load the BCD register, set `digit_valid[i]`, clear `blank_seen[i]`.
  - Blank: keep the BCD register, set `blank_seen[i]`, set `digit_valid[i]`.
  - Any other code: BCD register unchanged, `err` pulse.
- **Capture, anode all-ones (`4'b1111`).** Treated as display off: no capture, no error.
- **Capture, any other anode pattern.** `err` pulse; no register changes.
- **Frame mask.** A 4-bit mask records positions captured since the last frame. When a capture completes the mask (all four bits set), `frame_done` pulses and the mask clears. Repeat captures of the same position do not re-pulse.
- **Timeout counter.** Reset on every legal capture. When it reaches `TIMEOUT_CYCLES-1`, `digit_valid` and the frame mask clear and the counter restarts. BCD values are retained.
- **Simultaneous timeout and capture in one cycle:** the capture wins, and its valid bit is set.
- **`err_count`:** saturates at 255; it does not wrap.

## Timing
- **Reset values:** all BCD outputs 0, `digit_valid` 0, `blank_seen` 0, `frame_done` 0, `err` 0, `err_count` 0.
- **Reset internals:** synchronizers reset to all-ones (bus idle), state SETTLE, counters 0.
- **Reset mid-dwell:** the dwell is discarded. After release, a new full `STABLE_CYCLES` dwell is required.
- **Latency:** with both buses held constant from the rising edge at which they change, outputs reflect the capture on edge `STABLE_CYCLES+3`. That is 2 synchronizer edges, `STABLE_CYCLES` dwell, and 1 output register.
- **Same-edge outputs:** `frame_done` and `err` assert on the same edge as the output update.
- **Short dwell:** a bus change with a dwell shorter than `STABLE_CYCLES` produces no capture.
- **Minimum dwell:** the display drives a 300 Hz scan, so each dwell is about 333,000 cycles, far above `STABLE_CYCLES`.

## Configuration
- **`SEG_SCAN_ERR_EN` defined:** `err` and `err_count` behave as above.
- **`SEG_SCAN_ERR_EN` undefined:** both outputs are tied to 0, the counter logic is removed, and illegal anode or segment codes are silently ignored with no register change.

## Structure
- **Package `seg_scan_pkg`:**
  - active-low segment constants for 0–9 and blank;
  - the four anode select constants and `ANODE_OFF`;
  - position index constants (SEC0=0 … MIN1=3);
  - a decode function returning {valid, blank, bcd[3:0]}.
- **Sub-module `seg_bus_sync`:** parameterized-width 2-flop synchronizer with an async active-low reset value, instantiated once for the 12-bit concatenated bus.

## Test plan
- Reset, then `anode_count=1110`, `seven_seg=8'hA4` held for 40 cycles with `STABLE_CYCLES=16` → `sec0=2` and `digit_valid=0001` on edge 19; no `err`.
- Scan positions 0–3 with codes `C0, 92, F9, 90` → `sec0=0`, `sec1=5`, `min0=1`, `min1=9`; `frame_done` pulses once, on the min1 capture edge.
- min0 alternates between `B0` and `FF` (blink) → `min0` stays 3; `blank_seen[2]` toggles 0/1 per dwell; `digit_valid[2]` stays 1.
- Glitch: `sec1` code changed for 5 cycles mid-dwell, then restored → no capture during the glitch; a fresh capture occurs 16 cycles after restore with an unchanged value.
- `anode_count=1100` held 20 cycles → one `err` pulse and `err_count=1` (macro on); with macro off, `err` stays 0.
- No bus activity for `TIMEOUT_CYCLES` after a full frame → `digit_valid=0000` with BCD values retained; assert `rst` low mid-dwell → all outputs 0 immediately.
